// File: rtl/dvp_pkg.sv
// Shared constants for the DVP sensor emulator: FSM encoding, colour-bar table, line length.
package dvp_pkg;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StVsync  = 3'd1;
  localparam logic [2:0] StVbp    = 3'd2;
  localparam logic [2:0] StActive = 3'd3;
  localparam logic [2:0] StHblk   = 3'd4;
  localparam logic [2:0] StVfp    = 3'd5;

  // white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [15:0] BAR_RGB565 [0:7] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

  function automatic int unsigned line_len(input int unsigned im_x, input int unsigned hblank);
    return 2 * im_x + hblank;
  endfunction

  localparam int unsigned LINE_LEN = line_len(1280, 32);

endpackage

// File: rtl/dvp_pattern_gen.sv
// Test-pattern word generator. The word is registered on ld_i so it is ready one byte slot
// before the timing FSM needs it; x_i must step by one per load except when restarting at 0.
module dvp_pattern_gen
  import dvp_pkg::*;
#(
  parameter int unsigned IM_X    = 1280,
  parameter int unsigned PATTERN = 0,
  parameter int unsigned XW      = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_i,
  input  logic [XW-1:0] x_i,
  input  logic [15:0]   y_i,
  input  logic [7:0]    frame_cnt_i,
  output logic [15:0]   word_o
);

  localparam logic [XW-1:0] BarLast = XW'(IM_X / 8 - 1);

  logic [2:0]    bar_q, bar_d;
  logic [XW-1:0] bar_px_q, bar_px_d;
  logic [15:0]   word_q, word_d;

  always_comb begin
    bar_d    = bar_q;
    bar_px_d = bar_px_q;
    word_d   = word_q;
    if (ld_i) begin
      // Bar index tracks x incrementally so no divider is needed
      if (x_i == '0) begin
        bar_d    = 3'd0;
        bar_px_d = '0;
      end else if (bar_px_q == BarLast) begin
        bar_d    = bar_q + 3'd1;
        bar_px_d = '0;
      end else begin
        bar_px_d = bar_px_q + 1'b1;
      end
      if (PATTERN == 1) begin
        word_d = {{(16 - XW){1'b0}}, x_i} + y_i + {8'h00, frame_cnt_i};
      end else begin
        word_d = BAR_RGB565[bar_d];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bar_q    <= 3'd0;
      bar_px_q <= '0;
      word_q   <= 16'h0000;
    end else begin
      bar_q    <= bar_d;
      bar_px_q <= bar_px_d;
      word_q   <= word_d;
    end
  end

  assign word_o = word_q;

endmodule

// File: rtl/dvp_sensor_emu.sv
// DVP camera-sensor emulator: frame timing FSM driving VSYNC/HREF and RGB565 bytes, high first.
// All outputs are registered from next-state values so they align with the FSM state.
module dvp_sensor_emu
  import dvp_pkg::*;
#(
  parameter int unsigned IM_X      = 1280,
  parameter int unsigned IM_Y      = 720,
  parameter int unsigned VSYNC_LEN = 16,
  parameter int unsigned VBP_LINES = 4,
  parameter int unsigned VFP_LINES = 2,
  parameter int unsigned HBLANK    = 32,
  parameter int unsigned PATTERN   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  output logic       VSYNC_cam,
  output logic       HREF_cam,
  output logic [7:0] data_cam,
  output logic [7:0] frame_cnt,
  output logic       frame_done
);

  localparam int unsigned XW      = (IM_X > 1) ? $clog2(IM_X) : 1;
  localparam int unsigned LineLen = line_len(IM_X, HBLANK);

  localparam logic [15:0]   LineLast  = 16'(LineLen - 1);
  localparam logic [15:0]   VsyncLast = 16'(VSYNC_LEN - 1);
  localparam logic [15:0]   HblkLast  = 16'(HBLANK - 1);
  localparam logic [15:0]   VbpLast   = 16'(VBP_LINES - 1);
  localparam logic [15:0]   VfpLast   = 16'(VFP_LINES - 1);
  localparam logic [15:0]   YMax      = 16'(IM_Y);
  localparam logic [XW-1:0] XLast     = XW'(IM_X - 1);

  logic [2:0]    state_q, state_d;
  logic [15:0]   cyc_q, cyc_d;
  logic [15:0]   line_q, line_d;
  logic [15:0]   y_q, y_d;
  logic [XW-1:0] x_q, x_d;
  logic          odd_q, odd_d;
  logic [7:0]    fc_q, fc_d;
  logic          vsync_q, vsync_d;
  logic          href_q, href_d;
  logic [7:0]    data_q, data_d;
  logic          done_q, done_d;
  logic          start, frame_end;

  logic          gen_ld;
  logic [XW-1:0] gen_x;
  logic [15:0]   word;

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    line_d    = line_q;
    y_d       = y_q;
    x_d       = x_q;
    odd_d     = odd_q;
    fc_d      = fc_q;
    start     = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      StIdle: begin
        if (enable) start = 1'b1;
      end
      StVsync: begin
        if (cyc_q == VsyncLast) begin
          state_d = StVbp;
          cyc_d   = 16'd0;
          line_d  = 16'd0;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      StVbp: begin
        if (cyc_q == LineLast) begin
          cyc_d = 16'd0;
          if (line_q == VbpLast) begin
            state_d = StActive;
            x_d     = '0;
            odd_d   = 1'b0;
          end else begin
            line_d = line_q + 16'd1;
          end
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      StActive: begin
        odd_d = ~odd_q;
        if (odd_q) begin
          if (x_q == XLast) begin
            state_d = StHblk;
            cyc_d   = 16'd0;
            x_d     = '0;
            y_d     = y_q + 16'd1;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      StHblk: begin
        if (cyc_q == HblkLast) begin
          cyc_d = 16'd0;
          if (y_q < YMax) begin
            state_d = StActive;
            odd_d   = 1'b0;
          end else if (VFP_LINES != 0) begin
            state_d = StVfp;
            line_d  = 16'd0;
          end else begin
            frame_end = 1'b1;
          end
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      StVfp: begin
        if (cyc_q == LineLast) begin
          cyc_d = 16'd0;
          if (line_q == VfpLast) frame_end = 1'b1;
          else                   line_d = line_q + 16'd1;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // enable is only looked at here, so a frame in flight always completes
    if (frame_end) begin
      if (enable) start = 1'b1;
      else        state_d = StIdle;
    end
    if (start) begin
      state_d = StVsync;
      cyc_d   = 16'd0;
      y_d     = 16'd0;
      fc_d    = fc_q + 8'd1;
    end
  end

  always_comb begin
    vsync_d = (state_d == StVsync);
    href_d  = (state_d == StActive);
    data_d  = href_d ? (odd_d ? word[7:0] : word[15:8]) : 8'h00;
    if (VFP_LINES != 0) begin
      done_d = (state_d == StVfp) && (cyc_d == LineLast) && (line_d == VfpLast);
    end else begin
      done_d = (state_d == StHblk) && (cyc_d == HblkLast) && (y_d == YMax);
    end
  end

  // Blank cycles preload pixel 0 of the coming line; active even slots fetch the next pixel
  assign gen_ld = ((state_q == StActive) && !odd_q) || (state_q == StVbp) || (state_q == StHblk);
  assign gen_x  = (state_q == StActive) ? x_q + 1'b1 : '0;

  dvp_pattern_gen #(
    .IM_X   (IM_X),
    .PATTERN(PATTERN),
    .XW     (XW)
  ) u_pattern_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_i       (gen_ld),
    .x_i        (gen_x),
    .y_i        (y_q),
    .frame_cnt_i(fc_q),
    .word_o     (word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cyc_q   <= 16'd0;
      line_q  <= 16'd0;
      y_q     <= 16'd0;
      x_q     <= '0;
      odd_q   <= 1'b0;
      fc_q    <= 8'd0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      line_q  <= line_d;
      y_q     <= y_d;
      x_q     <= x_d;
      odd_q   <= odd_d;
      fc_q    <= fc_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign VSYNC_cam  = vsync_q;
  assign HREF_cam   = href_q;
  assign data_cam   = data_q;
  assign frame_cnt  = fc_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_dvp_sensor_emu.sv
// Directed bench for dvp_sensor_emu: one colour-bar and one gradient instance on shared stimulus.
module tb_dvp_sensor_emu;

  localparam int FrameLen = 146;
  localparam int TraceLen = 450;
  localparam int IdleIdx  = 438;
  localparam logic [7:0] BarLine [16] = '{
    8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
    8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00
  };

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       vs0, hr0, fd0, vs1, hr1, fd1;
  logic [7:0] d0, d1, fc0, fc1;

  int n_checks = 0;
  int n_errors = 0;
  int blank_viol = 0;

  logic       vs_t [TraceLen];
  logic       hr_t [TraceLen];
  logic       fd_t [TraceLen];
  logic [7:0] d0_t [TraceLen];
  logic [7:0] d1_t [TraceLen];
  logic [7:0] fc_t [TraceLen];

  dvp_sensor_emu #(
    .IM_X(8), .IM_Y(4), .VSYNC_LEN(6), .VBP_LINES(2), .VFP_LINES(1), .HBLANK(4), .PATTERN(0)
  ) u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .VSYNC_cam (vs0),
    .HREF_cam  (hr0),
    .data_cam  (d0),
    .frame_cnt (fc0),
    .frame_done(fd0)
  );

  dvp_sensor_emu #(
    .IM_X(8), .IM_Y(4), .VSYNC_LEN(6), .VBP_LINES(2), .VFP_LINES(1), .HBLANK(4), .PATTERN(1)
  ) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .VSYNC_cam (vs1),
    .HREF_cam  (hr1),
    .data_cam  (d1),
    .frame_cnt (fc1),
    .frame_done(fd1)
  );

  always #5 clk = ~clk;

  // Bus must be zero outside HREF
  always @(negedge clk) begin
    if (rst_n) begin
      blank_viol <= blank_viol + ((!hr0 && d0 != 8'h00) ? 1 : 0)
                                + ((!hr1 && d1 != 8'h00) ? 1 : 0);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    int act, vs_cnt, first_hr, hr_rises, line_mm;
    int mm_vs, mm_hr, mm_fd, mm_d0, mm_d1, mm_fc;
    int k, r, b;
    logic e_vs, e_hr, e_fd;
    logic [7:0] e_d0, e_d1, e_fc;
    logic [15:0] w;

    repeat (3) @(negedge clk);
    check_eq("reset_outputs", {vs0, hr0, d0, fc0, fd0, vs1, hr1, d1, fc1, fd1}, 0);
    rst_n = 1'b1;
    act = 0;
    repeat (10) begin
      @(negedge clk);
      act += int'(vs0 | hr0 | fd0 | (fc0 != 8'd0));
    end
    check_eq("idle_no_activity", act, 0);

    // Three frames back to back, enable dropped mid third frame
    enable = 1'b1;
    for (int i = 0; i < TraceLen; i++) begin
      @(negedge clk);
      vs_t[i] = vs0;
      hr_t[i] = hr0;
      fd_t[i] = fd0;
      d0_t[i] = d0;
      d1_t[i] = d1;
      fc_t[i] = fc0;
      if (i == 342) enable = 1'b0;
    end

    vs_cnt = 0;
    first_hr = -1;
    hr_rises = 0;
    for (int i = 0; i < FrameLen; i++) begin
      vs_cnt += int'(vs_t[i]);
      if (hr_t[i] && first_hr < 0) first_hr = i;
      if (i > 0 && hr_t[i] && !hr_t[i-1]) hr_rises++;
    end
    check_eq("vsync_high_len", vs_cnt, 6);
    check_eq("href_first_rise", first_hr, 46);
    check_eq("href_pulses", hr_rises, 4);
    check_eq("p1_y2x3_hi", d1_t[92], 8'h00);
    check_eq("p1_y2x3_lo", d1_t[93], 8'h06);

    line_mm = 0;
    for (int j = 0; j < 16; j++) line_mm += int'(d0_t[146 + 46 + 60 + j] != BarLine[j]);
    check_eq("p0_frame1_line3", line_mm, 0);

    check_eq("done_then_vsync_f0", {fd_t[145], vs_t[145], vs_t[146]}, 3'b101);
    check_eq("done_then_vsync_f1", {fd_t[291], vs_t[291], vs_t[292]}, 3'b101);
    check_eq("done_then_idle_f2", {fd_t[437], vs_t[438], fc_t[449]}, {1'b1, 1'b0, 8'd3});

    mm_vs = 0; mm_hr = 0; mm_fd = 0; mm_d0 = 0; mm_d1 = 0; mm_fc = 0;
    for (int i = 0; i < TraceLen; i++) begin
      k = i / FrameLen;
      r = i % FrameLen;
      e_vs = 1'b0; e_hr = 1'b0; e_fd = 1'b0; e_d0 = 8'h00; e_d1 = 8'h00;
      e_fc = (i < IdleIdx) ? 8'(k + 1) : 8'd3;
      if (i < IdleIdx) begin
        e_vs = (r < 6);
        e_fd = (r == 145);
        if (r >= 46 && r < 126 && ((r - 46) % 20) < 16) begin
          e_hr = 1'b1;
          b = (r - 46) % 20;
          e_d0 = BarLine[b];
          w = 16'(b / 2 + (r - 46) / 20 + k + 1);
          e_d1 = (b % 2 == 1) ? w[7:0] : w[15:8];
        end
      end
      mm_vs += int'(vs_t[i] !== e_vs);
      mm_hr += int'(hr_t[i] !== e_hr);
      mm_fd += int'(fd_t[i] !== e_fd);
      mm_d0 += int'(d0_t[i] !== e_d0);
      mm_d1 += int'(d1_t[i] !== e_d1);
      mm_fc += int'(fc_t[i] !== e_fc);
    end
    check_eq("vsync_trace", mm_vs, 0);
    check_eq("href_trace", mm_hr, 0);
    check_eq("done_trace", mm_fd, 0);
    check_eq("p0_data_trace", mm_d0, 0);
    check_eq("p1_data_trace", mm_d1, 0);
    check_eq("frame_cnt_trace", mm_fc, 0);

    // Asynchronous reset in the middle of an active line
    enable = 1'b1;
    repeat (51) @(negedge clk);
    check_eq("href_before_reset", {hr0, d0}, {1'b1, 8'h07});
    #2 rst_n = 1'b0;
    #1 check_eq("reset_mid_active", {vs0, hr0, d0, fc0, vs1, hr1, d1, fc1}, 0);
    enable = 1'b0;
    repeat (2) @(negedge clk);

    // frame_cnt wrap after 256 frames
    rst_n  = 1'b1;
    enable = 1'b1;
    repeat (255 * FrameLen) @(negedge clk);
    check_eq("fc_before_wrap", {fd0, fc0}, {1'b1, 8'd255});
    @(negedge clk);
    check_eq("fc_wrap", {vs0, fc0}, {1'b1, 8'd0});

    check_eq("blank_data_zero", blank_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
